clock_set_ctrl: RTL

//  Button-driven mode controller for the 6-digit HH:MM:SS clock.

---
 rtl/clock_set_ctrl_pkg.sv | 47 ++++
 rtl/clock_set_ctrl_if.sv | 24 ++
 rtl/clock_set_ctrl_debounce.sv | 46 ++++
 rtl/clock_set_ctrl.sv | 138 +++++++++++++
 4 files changed

// File: rtl/clock_set_ctrl_pkg.sv
// Shared types and constants for the clock-setting controller: mode encoding,
// digit indices (same order the scanner and counters use) and button indices.
package clock_set_ctrl_pkg;

  typedef enum logic [1:0] {
    ModeRun     = 2'd0,
    ModeSetHour = 2'd1,
    ModeSetMin  = 2'd2,
    ModeSetSec  = 2'd3
  } mode_e;

  localparam int unsigned NumDigits = 6;
  localparam int unsigned DigSec1   = 0;
  localparam int unsigned DigSec10  = 1;
  localparam int unsigned DigMin1   = 2;
  localparam int unsigned DigMin10  = 3;
  localparam int unsigned DigHr1    = 4;
  localparam int unsigned DigHr10   = 5;

  localparam int unsigned NumBtns = 3;
  localparam int unsigned BtnMode = 0;
  localparam int unsigned BtnUp   = 1;
  localparam int unsigned BtnClr  = 2;

  // Digit pair that belongs to the field being edited in a given mode.
  function automatic logic [NumDigits-1:0] blank_mask(mode_e m);
    logic [NumDigits-1:0] mask;
    mask = '0;
    unique case (m)
      ModeSetHour: begin
        mask[DigHr10] = 1'b1;
        mask[DigHr1]  = 1'b1;
      end
      ModeSetMin: begin
        mask[DigMin10] = 1'b1;
        mask[DigMin1]  = 1'b1;
      end
      ModeSetSec: begin
        mask[DigSec10] = 1'b1;
        mask[DigSec1]  = 1'b1;
      end
      default: ;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Board-side bundle of the clock-setting controller: raw buttons in, run gate,
// counter pulses, blink mask and current mode out.
interface clock_set_ctrl_if;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_clr;
  logic       run_en;
  logic       inc_hour;
  logic       inc_min;
  logic       inc_sec;
  logic       clr_sec;
  logic [5:0] digit_blank;
  logic [1:0] mode;

  modport master (
    input  btn_mode, btn_up, btn_clr,
    output run_en, inc_hour, inc_min, inc_sec, clr_sec, digit_blank, mode
  );

  modport slave (
    output btn_mode, btn_up, btn_clr,
    input  run_en, inc_hour, inc_min, inc_sec, clr_sec, digit_blank, mode
  );
endinterface

// File: rtl/clock_set_ctrl_debounce.sv
// One push-button conditioner: 2-FF synchronizer followed by a debouncer whose
// level only follows the synced input after DEBOUNCE_CYC consecutive disagreeing cycles.
module clock_set_ctrl_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic [1:0]      sync_q, sync_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;

  always_comb begin
    sync_d  = {sync_q[0], btn_i};
    cnt_d   = '0;
    level_d = level_q;
    // Any agreeing sample restarts the run, so only an unbroken run is accepted.
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYC - 1)) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode controller for the HH:MM:SS clock: conditions three buttons, walks the
// RUN/SET_HOUR/SET_MIN/SET_SEC cycle, emits counter pulses and the blink mask.
module clock_set_ctrl
  import clock_set_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 20,
  parameter int unsigned BLINK_HALF   = 250,
  parameter int unsigned REPEAT_DLY   = 500,
  parameter int unsigned REPEAT_RATE  = 100
) (
  input logic              clk,
  input logic              rst,
  clock_set_ctrl_if.master bus
);

  localparam int unsigned RepW   = $clog2(REPEAT_DLY + 1);
  localparam int unsigned BlinkW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  // Reloading here lands the next match with REPEAT_DLY exactly REPEAT_RATE cycles later.
  localparam logic [RepW-1:0] RepReload = RepW'(REPEAT_DLY - REPEAT_RATE + 1);

  logic [NumBtns-1:0] btn_raw, btn_lvl, btn_ev;
  logic [NumBtns-1:0] lvl_prev_q, lvl_prev_d;

  mode_e             mode_q, mode_d;
  logic [RepW-1:0]   rep_q, rep_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              phase_q, phase_d;
  logic              inc_hour_q, inc_hour_d;
  logic              inc_min_q, inc_min_d;
  logic              inc_sec_q, inc_sec_d;
  logic              clr_sec_q, clr_sec_d;
  logic              up_fire, clr_fire;

  assign btn_raw[BtnMode] = bus.btn_mode;
  assign btn_raw[BtnUp]   = bus.btn_up;
  assign btn_raw[BtnClr]  = bus.btn_clr;

  for (genvar i = 0; i < NumBtns; i++) begin : g_btn
    clock_set_ctrl_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (btn_raw[i]),
      .level_o(btn_lvl[i])
    );
  end

  assign btn_ev = btn_lvl & ~lvl_prev_q;

  always_comb begin
    lvl_prev_d  = btn_lvl;
    mode_d      = mode_q;
    rep_d       = '0;
    blink_cnt_d = '0;
    phase_d     = 1'b0;
    inc_hour_d  = 1'b0;
    inc_min_d   = 1'b0;
    inc_sec_d   = 1'b0;
    clr_sec_d   = 1'b0;
    up_fire     = 1'b0;
    clr_fire    = 1'b0;

    if (btn_ev[BtnMode]) begin
      // Mode press swallows any up/clr event of the same cycle.
      case (mode_q)
        ModeRun:     mode_d = ModeSetHour;
        ModeSetHour: mode_d = ModeSetMin;
        ModeSetMin:  mode_d = ModeSetSec;
        default:     mode_d = ModeRun;
      endcase
    end else if (mode_q != ModeRun) begin
      if (btn_lvl[BtnUp]) begin
        if (btn_ev[BtnUp]) begin
          rep_d   = RepW'(1);
          up_fire = 1'b1;
        end else if (rep_q == RepW'(REPEAT_DLY)) begin
          rep_d   = RepReload;
          up_fire = 1'b1;
        end else if (rep_q != '0) begin
          rep_d = rep_q + 1'b1;
        end
      end

      clr_fire = btn_ev[BtnClr] && (mode_q == ModeSetSec);
      if (clr_fire) begin
        clr_sec_d = 1'b1;
      end else if (up_fire) begin
        unique case (mode_q)
          ModeSetHour: inc_hour_d = 1'b1;
          ModeSetMin:  inc_min_d  = 1'b1;
          ModeSetSec:  inc_sec_d  = 1'b1;
          default: ;
        endcase
      end

      if (blink_cnt_q == BlinkW'(BLINK_HALF - 1)) begin
        phase_d = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_prev_q  <= '0;
      mode_q      <= ModeRun;
      rep_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      inc_hour_q  <= 1'b0;
      inc_min_q   <= 1'b0;
      inc_sec_q   <= 1'b0;
      clr_sec_q   <= 1'b0;
    end else begin
      lvl_prev_q  <= lvl_prev_d;
      mode_q      <= mode_d;
      rep_q       <= rep_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      inc_hour_q  <= inc_hour_d;
      inc_min_q   <= inc_min_d;
      inc_sec_q   <= inc_sec_d;
      clr_sec_q   <= clr_sec_d;
    end
  end

  assign bus.run_en      = (mode_q == ModeRun);
  assign bus.mode        = mode_q;
  assign bus.digit_blank = phase_q ? blank_mask(mode_q) : '0;
  assign bus.inc_hour    = inc_hour_q;
  assign bus.inc_min     = inc_min_q;
  assign bus.inc_sec     = inc_sec_q;
  assign bus.clr_sec     = clr_sec_q;

endmodule
